paint_brush_sequencer: RTL and testbench
========================================

Name: paint_brush_sequencer

Overview:
- Sequences VGA-adapter pixel writes for the paint controller.
- Turns one brush-stamp request (cursor x/y, colour, size, mode) into a raster burst of single-pixel writes, one per clock, covering an N×N square.
- Also runs a full-screen clear.
- Sits between the switch-decoding controller (colour/size/mode selects) and the 160×120 VGA adapter's x/y/colour/plot inputs.

Parameters:
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COLOUR_W, 3, colour width (RGB 1-1-1).
- BG_COLOUR, 3'b000, colour written by erase mode and by clear.

Ports:
- Clock  in  1  system clock (50 MHz); all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- go  in  1  stamp request; sampled each rising edge.
- clear_req  in  1  full-screen clear request; sampled each rising edge.
- x_in  in  X_W  brush top-left x.
- y_in  in  Y_W  brush top-left y.
- colour_in  in  COLOUR_W  paint colour.
- size_sel  in  2  brush side: 00=1, 01=2, 10=4, 11=8 pixels.
- mode  in  1  0=paint with colour_in, 1=erase with BG_COLOUR.
- x_out  out  X_W  pixel x to VGA adapter.
- y_out  out  Y_W  pixel y to VGA adapter.
- colour_out  out  COLOUR_W  pixel colour to VGA adapter.
- plot  out  1  write enable to VGA adapter.
- busy  out  1  high while a stamp or clear is in progress.
- done  out  1  one-cycle pulse after the last pixel of a stamp or clear.

Behaviour:
- Reset (async, Reset=1): state IDLE; x_out=0, y_out=0, colour_out=0; plot=0, busy=0, done=0; internal counters cleared.
- Reset asserted mid-burst aborts immediately: no further plot, and no done pulse.
- All outputs are registered.
- States:
  - IDLE: waiting for a request.
  - DRAW: stamping the brush square.
  - CLEAR: writing every screen pixel.
  - FIN: one cycle, done=1.
- IDLE, request priority:
  - clear_req=1 at an edge → CLEAR. clear_req wins if go is also high at the same edge.
  - Otherwise go=1 → DRAW. At this edge x_in, y_in, size_sel and the effective colour are latched. Effective colour is colour_in if mode=0, BG_COLOUR if mode=1.
  - Inputs may change freely after the accepting edge.
- Latency: the accepting edge t also registers the first pixel. In the cycle after t: busy=1, x_out=x0, y_out=y0, plot as defined below.
- DRAW ordering:
  - dx counts 0..N-1, then dx wraps and dy increments, up to dy=N-1.
  - Outputs: x_out=x0+dx, y_out=y0+dy.
  - The sum is computed one bit wider, so a clipped coordinate is detected rather than wrapped.
  - Exactly N×N cycles are spent in DRAW.
- Clipping: a pixel with x0+dx ≥ SCREEN_W or y0+dy ≥ SCREEN_H still consumes its cycle, with plot=0. x_out/y_out then show the truncated value and are don't-care.
- CLEAR:
  - Scans x 0..SCREEN_W-1 inner and y 0..SCREEN_H-1 outer, with colour_out=BG_COLOUR and plot=1.
  - Takes exactly SCREEN_W×SCREEN_H = 19200 cycles.
- FIN:
  - Entered in the cycle after the last pixel cycle: plot=0, busy=0, done=1.
  - Next edge goes to IDLE.
  - A go or clear_req sampled at the FIN→IDLE edge is accepted as if in IDLE, allowing back-to-back requests with one idle cycle.
- go or clear_req while busy=1 is ignored; requests are not queued.
- plot is never high while busy=0.

Optional Feature:
- Macro: PAINT_BRUSH_ROUND_EN.
- Defined: for N≥4, the four corner pixels (dx∈{0,N-1} and dy∈{0,N-1}) are emitted with plot=0, giving a rounded brush. Cycle count is unchanged (N×N).
- Undefined: square brush; every in-screen pixel has plot=1.
- Sizes 1 and 2 are identical in both builds.

Test Plan:
- Reset mid-DRAW: go with size_sel=11 at (10,10); assert Reset after 20 pixel cycles → all outputs 0 asynchronously; no done; after release, the next go works normally.
- Basic stamp: go, x_in=20, y_in=30, size_sel=01, colour_in=3'b100, mode=0 → 4 plot cycles at (20,30),(21,30),(20,31),(21,31) with colour 100; then done for 1 cycle with busy=0.
- Erase plus clipping: go at (158,118), size_sel=10, mode=1 → 16 DRAW cycles; plot=1 only for x∈{158,159}, y∈{118,119} (4 pixels), colour 000; the other 12 cycles have plot=0.
- Priority/ignore: go and clear_req high together → CLEAR, 19200 plot cycles, last pixel (159,119); a go pulse during CLEAR is ignored; done pulses once.
- Back-to-back: hold go=1 with size_sel=00 → plots every other cycle pattern (DRAW, FIN, DRAW…); each stamp gives exactly 1 plot and 1 done.
- PAINT_BRUSH_ROUND_EN build: go at (0,0), size_sel=10 → 16 cycles, 12 plots; corners (0,0),(3,0),(0,3),(3,3) have plot=0. Without the macro, the same stimulus gives 16 plots.

Source files
------------

// File: rtl/paint_brush_sequencer_if.sv
// paint_brush_sequencer_if
// Bundles the request side (controller -> sequencer) and the pixel side
// (sequencer -> VGA adapter) of the paint brush sequencer.
//   go, clear_req              stamp / full-screen clear requests
//   x_in, y_in                 brush top-left corner
//   colour_in, size_sel, mode  paint colour, brush side select, erase select
//   x_out, y_out, colour_out   pixel to write
//   plot                       VGA write enable
//   busy, done                 burst in progress / one-cycle completion pulse
// Modports: master = request source / pixel sink, slave = the sequencer.
interface paint_brush_sequencer_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                go;
    logic                clear_req;
    logic [X_W-1:0]      x_in;
    logic [Y_W-1:0]      y_in;
    logic [COLOUR_W-1:0] colour_in;
    logic [1:0]          size_sel;
    logic                mode;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [COLOUR_W-1:0] colour_out;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output go, clear_req, x_in, y_in, colour_in, size_sel, mode,
        input  x_out, y_out, colour_out, plot, busy, done
    );

    modport slave (
        input  go, clear_req, x_in, y_in, colour_in, size_sel, mode,
        output x_out, y_out, colour_out, plot, busy, done
    );
endinterface

// File: rtl/paint_brush_sequencer.sv
// paint_brush_sequencer
// Turns a brush-stamp request into a raster burst of single-pixel VGA writes
// covering an N x N square (N = 1, 2, 4, 8), one pixel per clock, and runs a
// full-screen clear in background colour. All outputs are registered; the
// accepting edge already registers the first pixel.
// Ports:
//   Clock  system clock, rising-edge
//   Reset  asynchronous, active-high; aborts any burst without a done pulse
//   bus    paint_brush_sequencer_if.slave (requests in, pixel writes out)
// Build option:
//   PAINT_BRUSH_ROUND_EN  when defined, brushes of side >= 4 skip their four
//                         corner pixels (plot=0) for a rounded stamp.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | waiting for go / clear_req
// DRAW  | stamping the brush square, one pixel per cycle
// CLEAR | writing every screen pixel with BG_COLOUR
// FIN   | one cycle, done=1; requests accepted as in IDLE
module paint_brush_sequencer #(
    parameter int                  SCREEN_W  = 160,
    parameter int                  SCREEN_H  = 120,
    parameter int                  X_W       = 8,
    parameter int                  Y_W       = 7,
    parameter int                  COLOUR_W  = 3,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
    input  logic                    Clock,
    input  logic                    Reset,
    paint_brush_sequencer_if.slave  bus
);

`ifdef PAINT_BRUSH_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    localparam logic [X_W:0]   X_LIM  = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   Y_LIM  = (Y_W+1)'(SCREEN_H);
    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, DRAW, CLEAR, FIN} state_t;

    state_t         state;
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [2:0]     nm1;   // brush side minus one
    logic [2:0]     dx;
    logic [2:0]     dy;
    logic [X_W-1:0] cx;
    logic [Y_W-1:0] cy;

    logic           draw_last;
    logic [2:0]     nx_dx;
    logic [2:0]     nx_dy;
    logic [X_W:0]   nx_xs;
    logic [Y_W:0]   nx_ys;
    logic [2:0]     acc_nm1;
    logic           clr_last;
    logic [X_W-1:0] nx_cx;
    logic [Y_W-1:0] nx_cy;

    function automatic logic [2:0] side_m1(input logic [1:0] s);
        case (s)
            2'b00:   return 3'd0;
            2'b01:   return 3'd1;
            2'b10:   return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // Coordinates arrive one bit wider than the screen bus so a pixel past
    // the right/bottom edge is suppressed instead of wrapping to the left/top.
    function automatic logic pixel_on(input logic [X_W:0] xs, input logic [Y_W:0] ys,
                                      input logic [2:0] ddx, input logic [2:0] ddy,
                                      input logic [2:0] m1);
        logic corner;
        corner = ROUND_EN && (m1 >= 3'd3) &&
                 ((ddx == 3'd0) || (ddx == m1)) && ((ddy == 3'd0) || (ddy == m1));
        return (xs < X_LIM) && (ys < Y_LIM) && !corner;
    endfunction

    always_comb begin
        draw_last = (dx == nm1) && (dy == nm1);
        nx_dx     = (dx == nm1) ? 3'd0 : dx + 3'd1;
        nx_dy     = (dx == nm1) ? dy + 3'd1 : dy;
        nx_xs     = {1'b0, x0} + (X_W+1)'(nx_dx);
        nx_ys     = {1'b0, y0} + (Y_W+1)'(nx_dy);
        acc_nm1   = side_m1(bus.size_sel);
        clr_last  = (cx == X_LAST) && (cy == Y_LAST);
        nx_cx     = (cx == X_LAST) ? '0 : cx + 1'b1;
        nx_cy     = (cx == X_LAST) ? cy + 1'b1 : cy;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            x0             <= '0;
            y0             <= '0;
            nm1            <= '0;
            dx             <= '0;
            dy             <= '0;
            cx             <= '0;
            cy             <= '0;
            bus.x_out      <= '0;
            bus.y_out      <= '0;
            bus.colour_out <= '0;
            bus.plot       <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    bus.done <= 1'b0;
                    if (bus.clear_req) begin
                        state          <= CLEAR;
                        cx             <= '0;
                        cy             <= '0;
                        bus.x_out      <= '0;
                        bus.y_out      <= '0;
                        bus.colour_out <= BG_COLOUR;
                        bus.plot       <= 1'b1;
                        bus.busy       <= 1'b1;
                    end else if (bus.go) begin
                        state          <= DRAW;
                        x0             <= bus.x_in;
                        y0             <= bus.y_in;
                        nm1            <= acc_nm1;
                        dx             <= '0;
                        dy             <= '0;
                        bus.x_out      <= bus.x_in;
                        bus.y_out      <= bus.y_in;
                        bus.colour_out <= bus.mode ? BG_COLOUR : bus.colour_in;
                        bus.plot       <= pixel_on({1'b0, bus.x_in}, {1'b0, bus.y_in},
                                                   3'd0, 3'd0, acc_nm1);
                        bus.busy       <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.plot <= 1'b0;
                        bus.busy <= 1'b0;
                    end
                end
                DRAW: begin
                    if (draw_last) begin
                        state    <= FIN;
                        bus.plot <= 1'b0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        dx        <= nx_dx;
                        dy        <= nx_dy;
                        bus.x_out <= nx_xs[X_W-1:0];
                        bus.y_out <= nx_ys[Y_W-1:0];
                        bus.plot  <= pixel_on(nx_xs, nx_ys, nx_dx, nx_dy, nm1);
                    end
                end
                CLEAR: begin
                    if (clr_last) begin
                        state    <= FIN;
                        bus.plot <= 1'b0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        cx        <= nx_cx;
                        cy        <= nx_cy;
                        bus.x_out <= nx_cx;
                        bus.y_out <= nx_cy;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.plot <= 1'b0;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paint_brush_sequencer.sv
module tb_paint_brush_sequencer;

    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    always #10 Clock = ~Clock;

    paint_brush_sequencer_if bus ();

    paint_brush_sequencer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

`ifdef PAINT_BRUSH_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef struct {
        int x;
        int y;
        bit on;
    } pix_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the set of pixels a stamp must produce, in raster order.
    task automatic build_ref(input int x0, input int y0, input int n, output pix_t q[$]);
        pix_t p;
        q = {};
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                p.x  = x0 + c;
                p.y  = y0 + r;
                p.on = (p.x < 160) && (p.y < 120) &&
                       !(ROUND && n >= 4 && (c == 0 || c == n - 1) && (r == 0 || r == n - 1));
                q.push_back(p);
            end
        end
    endtask

    task automatic do_stamp(input int x0, input int y0, input int col, input int sz,
                            input int md, output int plots, output int ref_plots);
        pix_t q[$];
        int   n;
        int   ecol;
        n    = 1 << sz;
        ecol = md ? 0 : col;
        build_ref(x0, y0, n, q);
        plots     = 0;
        ref_plots = 0;
        @(negedge Clock);
        bus.x_in      = 8'(x0);
        bus.y_in      = 7'(y0);
        bus.colour_in = 3'(col);
        bus.size_sel  = 2'(sz);
        bus.mode      = md[0];
        bus.go        = 1'b1;
        @(posedge Clock);
        #1;
        bus.go        = 1'b0;
        bus.x_in      = 8'($urandom);
        bus.y_in      = 7'($urandom);
        bus.colour_in = 3'($urandom);
        bus.size_sel  = 2'($urandom);
        bus.mode      = 1'($urandom);
        foreach (q[i]) begin
            @(negedge Clock);
            chk("stamp_busy", 32'(bus.busy), 32'd1);
            chk("stamp_plot", 32'(bus.plot), 32'(q[i].on));
            if (bus.plot) plots++;
            if (q[i].on) begin
                ref_plots++;
                chk("stamp_x", 32'(bus.x_out), 32'(q[i].x));
                chk("stamp_y", 32'(bus.y_out), 32'(q[i].y));
                chk("stamp_colour", 32'(bus.colour_out), 32'(ecol));
            end
        end
        @(negedge Clock);
        chk("fin_done", 32'(bus.done), 32'd1);
        chk("fin_busy", 32'(bus.busy), 32'd0);
        chk("fin_plot", 32'(bus.plot), 32'd0);
        @(negedge Clock);
        chk("idle_done", 32'(bus.done), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int plots;
        int ref_plots;
        int done_cnt;

        Reset         = 1'b1;
        bus.go        = 1'b0;
        bus.clear_req = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.colour_in = '0;
        bus.size_sel  = '0;
        bus.mode      = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rst_x", 32'(bus.x_out), 32'd0);
        chk("rst_y", 32'(bus.y_out), 32'd0);
        chk("rst_colour", 32'(bus.colour_out), 32'd0);
        chk("rst_plot", 32'(bus.plot), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        chk("idle_plot", 32'(bus.plot), 32'd0);

        // Reset mid-DRAW
        bus.x_in      = 8'd10;
        bus.y_in      = 7'd10;
        bus.colour_in = 3'b111;
        bus.size_sel  = 2'b11;
        bus.mode      = 1'b0;
        bus.go        = 1'b1;
        @(posedge Clock);
        #1;
        bus.go = 1'b0;
        repeat (20) @(negedge Clock);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_x", 32'(bus.x_out), 32'd0);
        chk("arst_y", 32'(bus.y_out), 32'd0);
        chk("arst_colour", 32'(bus.colour_out), 32'd0);
        chk("arst_plot", 32'(bus.plot), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            chk("post_rst_plot", 32'(bus.plot), 32'd0);
            chk("post_rst_done", 32'(bus.done), 32'd0);
        end

        // Basic 2x2 stamp
        do_stamp(20, 30, 3'b100, 1, 0, plots, ref_plots);
        chk("basic_plots", 32'(plots), 32'd4);

        // Erase with clipping at the bottom-right corner
        do_stamp(158, 118, 3'b101, 2, 1, plots, ref_plots);
        chk("clip_plots", 32'(plots), ROUND ? 32'd3 : 32'd4);

        // Full 4x4 at origin: rounded build drops the four corners
        do_stamp(0, 0, 3'b010, 2, 0, plots, ref_plots);
        chk("round_plots", 32'(plots), ROUND ? 32'd12 : 32'd16);

        // Priority: clear_req wins over go; go during CLEAR is ignored
        @(negedge Clock);
        bus.go        = 1'b1;
        bus.clear_req = 1'b1;
        bus.colour_in = 3'b111;
        bus.mode      = 1'b0;
        @(posedge Clock);
        #1;
        bus.go        = 1'b0;
        bus.clear_req = 1'b0;
        done_cnt      = 0;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                @(negedge Clock);
                chk("clr_x", 32'(bus.x_out), 32'(x));
                chk("clr_y", 32'(bus.y_out), 32'(y));
                chk("clr_plot", 32'(bus.plot), 32'd1);
                if (x == 0) chk("clr_busy", 32'(bus.busy), 32'd1);
                if (bus.done) done_cnt++;
                bus.go = (y == 50 && x < 2);
            end
        end
        chk("clr_last_x", 32'(bus.x_out), 32'd159);
        chk("clr_last_y", 32'(bus.y_out), 32'd119);
        chk("clr_colour", 32'(bus.colour_out), 32'd0);
        @(negedge Clock);
        if (bus.done) done_cnt++;
        chk("clr_fin_plot", 32'(bus.plot), 32'd0);
        @(negedge Clock);
        if (bus.done) done_cnt++;
        chk("clr_done_count", 32'(done_cnt), 32'd1);
        chk("clr_idle_busy", 32'(bus.busy), 32'd0);

        // Back-to-back 1x1 stamps with go held high
        @(negedge Clock);
        bus.x_in      = 8'd5;
        bus.y_in      = 7'd6;
        bus.colour_in = 3'b011;
        bus.size_sel  = 2'b00;
        bus.mode      = 1'b0;
        bus.go        = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            chk("b2b_plot", 32'(bus.plot), 32'd1);
            chk("b2b_busy", 32'(bus.busy), 32'd1);
            chk("b2b_done_lo", 32'(bus.done), 32'd0);
            chk("b2b_x", 32'(bus.x_out), 32'(5 + k));
            chk("b2b_colour", 32'(bus.colour_out), 32'd3);
            bus.x_in = 8'(6 + k);
            @(negedge Clock);
            chk("b2b_done", 32'(bus.done), 32'd1);
            chk("b2b_fin_plot", 32'(bus.plot), 32'd0);
            chk("b2b_fin_busy", 32'(bus.busy), 32'd0);
            if (k == 3) bus.go = 1'b0;
        end
        @(negedge Clock);
        chk("b2b_end_busy", 32'(bus.busy), 32'd0);
        chk("b2b_end_done", 32'(bus.done), 32'd0);

        // Randomized stamps against the reference pixel set
        for (int t = 0; t < 16; t++) begin
            do_stamp(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 1)), plots, ref_plots);
            chk("rand_plots", 32'(plots), 32'(ref_plots));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
